// File: rtl/tx_fifo_byte_feeder_pkg.sv
// Shared constants and FSM encoding for the TX FIFO byte feeder.
package tx_fifo_byte_feeder_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;
    localparam int BYTE_W     = 8;

    // IDLE: no word held. SEND: a word is held and bytes are being written.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/tx_fifo_byte_feeder.sv
// Width down-converter: accepts wide words over valid/ready and writes them
// into the TX FIFO one byte per cycle, LSB first, stalling on i_full.
//
// Handshake: a word transfers on a rising edge where i_valid and o_ready are
// both high; upstream keeps i_data/i_nbytes stable while i_valid is high and
// o_ready is low. A byte transfers to the FIFO on every edge where o_wr_en is
// high; o_wr_en already accounts for i_full, so the FIFO never sees a write
// while full.
module tx_fifo_byte_feeder
    import tx_fifo_byte_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NB_W   = $clog2(DATA_W / 8) + 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_wr_clk,
    input  logic              i_wr_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic [NB_W-1:0]   i_nbytes,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_wr_en,
    output logic [7:0]        o_wr_data,
    input  logic              i_full,
    output logic              o_busy,
    output logic              o_word_done,
    output logic [CNT_W-1:0]  o_byte_cnt
);

    localparam logic [NB_W-1:0] FULL_NB = NB_W'(DATA_W / BYTE_W);

    feeder_state_t     r_state;
    logic [DATA_W-1:0] r_sh;
    logic [NB_W-1:0]   r_rem;
    logic [CNT_W-1:0]  r_byte_cnt;

    logic              w_send;
    logic              w_last;
    logic              w_write;
    logic              w_accept;
    logic [NB_W-1:0]   w_nbytes_eff;

    // Handshake and write-strobe decode; depends combinationally on the
    // registered i_full from the FIFO, so no loop is formed.
    always_comb begin
        w_send       = (r_state == ST_SEND);
        w_last       = (r_rem == NB_W'(1));
        w_write      = w_send & ~i_full & ~i_wr_rst;
        w_accept     = i_valid & ~i_wr_rst & (~w_send | (w_last & ~i_full));
        w_nbytes_eff = (i_nbytes == '0) ? FULL_NB : i_nbytes;
    end

    assign o_wr_en     = w_write;
    assign o_ready     = ~i_wr_rst & (~w_send | (w_last & ~i_full));
    assign o_word_done = w_write & w_last;
    assign o_busy      = w_send & ~i_wr_rst;
    assign o_wr_data   = r_sh[BYTE_W-1:0];
    assign o_byte_cnt  = r_byte_cnt;

    // FSM, shift register, remaining-byte counter and running byte counter.
    // A new accept in the last-byte cycle overrides the shift so the next
    // word starts with no bubble.
    always_ff @(posedge i_wr_clk) begin
        if (i_wr_rst) begin
            r_state    <= ST_IDLE;
            r_sh       <= '0;
            r_rem      <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (w_write) begin
                r_sh       <= r_sh >> BYTE_W;
                r_rem      <= r_rem - NB_W'(1);
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                if (w_last) begin
                    r_state <= ST_IDLE;
                end
            end
            if (w_accept) begin
                r_sh    <= i_data;
                r_rem   <= w_nbytes_eff;
                r_state <= ST_SEND;
            end
        end
    end

endmodule

// File: doc/tx_fifo_byte_feeder.md
# tx_fifo_byte_feeder

Width down-converter that sits directly upstream of the TX FIFO write-pointer/full-flag stage. It accepts wide data words from the DDR3 read-return path over a valid/ready handshake and splits each word into bytes, least-significant byte first. It drives the TX FIFO write enable and write data one byte per cycle, stalling whenever the FIFO reports full, so that no byte is dropped or duplicated.

## Interface
- DATA_W, 128, width of the input word; must be a multiple of 8, from 16 to 256
- NB_W, $clog2(DATA_W/8)+1, width of the byte-count and byte-index fields
- CNT_W, 16, width of the running byte counter
- i_wr_clk  in  1  single clock; all logic is on its rising edge
- i_wr_rst  in  1  synchronous, active-high reset
- i_data  in  DATA_W  input word; byte k is i_data[8k+7:8k]
- i_nbytes  in  NB_W  number of valid bytes in i_data, starting from byte 0; 0 means DATA_W/8
- i_valid  in  1  input word valid
- o_ready  out  1  feeder can accept a word this cycle
- o_wr_en  out  1  write strobe to the TX FIFO
- o_wr_data  out  8  byte to the TX FIFO
- i_full  in  1  registered FIFO full flag
- o_busy  out  1  a word is held and not yet fully written
- o_word_done  out  1  one-cycle pulse when the last byte of a word is written
- o_byte_cnt  out  CNT_W  total bytes written since reset; wraps modulo 2^CNT_W

## Operation
- FSM states:
  - IDLE: no word held.
  - SEND: word held in shift register `sh`, remaining-byte count `rem`.
- Word accept: the input word is accepted when i_valid and o_ready are both high.
  - On accept, `sh` loads i_data.
  - `rem` loads i_nbytes, with 0 mapped to DATA_W/8.
  - The FSM moves to SEND.
- Byte write: a byte is written when o_wr_en is high.
  - o_wr_en = (state == SEND) & ~i_full & ~i_wr_rst.
  - o_wr_data = sh[7:0] at all times; its value is don't-care in IDLE.
- On each byte write:
  - `sh` shifts right by 8, filling with zeros.
  - `rem` decrements.
  - o_byte_cnt increments by 1.
- Last byte (`rem` == 1 and a byte is written):
  - o_word_done pulses high in that same cycle.
  - If i_valid is also high, the next word loads and the state stays SEND with no bubble.
  - Otherwise the FSM goes to IDLE.
- o_ready is high when:
  - the state is IDLE, or
  - the state is SEND, `rem` == 1 and i_full is low.
  - o_ready is always 0 while i_wr_rst is high.
- o_busy is high exactly when the state is SEND.
- i_full stall: while i_full is high, `sh`, `rem` and o_byte_cnt hold and o_wr_en is 0. Writing resumes in the first cycle i_full is low.
- Unused bytes above `rem` in a partial word are never written.

## Timing
- Reset (i_wr_rst sampled high) sets:
  - state to IDLE, `sh` to 0, `rem` to 0;
  - o_byte_cnt to 0;
  - o_wr_en, o_ready, o_busy and o_word_done to 0 during the reset cycle.
  - In the first cycle after reset, o_ready = 1.
- Reset mid-word: the held word is discarded with no further writes. The FIFO is reset in the same cycle.
- Latency: a word accepted at edge N produces its first o_wr_en in cycle N+1 if i_full is low.
- Throughput: a word of n bytes occupies n cycles. With the back-to-back accept, the sustained rate is 1 byte per clock.
- o_wr_en, o_ready and o_word_done depend combinationally on i_full, which is registered at the FIFO. No combinational loop exists.
- i_data and i_nbytes are sampled only in the accept cycle. Upstream holds them stable while i_valid is high and o_ready is low.
- o_byte_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- A shared package holds:
  - the DATA_W and CNT_W defaults;
  - the byte-width constant 8;
  - the FSM state encoding, IDLE = 1'b0 and SEND = 1'b1.
- Single module with no sub-module. The shift register, down-counter and FSM are small enough to stay together.

## Test plan
- Full word: i_data = 128'h0F0E…0100, i_nbytes = 0, i_full = 0 → 16 consecutive o_wr_en carrying bytes 00..0F, o_word_done on the 16th write, o_byte_cnt = 16.
- Partial word: i_nbytes = 3, i_data[23:0] = 24'hC0B0A0 → bytes A0, B0, C0, then IDLE; byte 3 is never written; o_byte_cnt = 3.
- Back-to-back: two 16-byte words with i_valid held high → 32 writes in 32 consecutive cycles with no gap; o_ready is high only in the 16th cycle of the first word.
- Full stall: i_full asserted for 5 cycles after the 4th byte → o_wr_en = 0 for those 5 cycles, then byte 4 is written; no byte is duplicated or lost; total 16 writes.
- Reset mid-word: i_wr_rst high after the 7th byte → o_wr_en = 0 from that cycle on; after reset, o_byte_cnt = 0 and o_ready = 1; a new word is written from its byte 0.
- Counter wrap: with CNT_W = 4, write 17 bytes → o_byte_cnt reads 1.
